// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four packet sources share one FIFO write port.
// Latency: one IDLE cycle to grant, then winc follows the granted req_valid combinationally.
// Backpressure: wfull stalls the granted source (req_ready=0), grant and beat count held.
//
// Ports:
//   wclk, wrst           clock, asynchronous active-high reset
//   req_valid/data/last  per-source word valid, word (slice k*DW), end-of-packet flag
//   req_ready            per-source word-accepted strobe (equals winc on the granted source)
//   wfull, winc, wdata   FIFO write side
//   grant_id, busy       current grant index, high while a grant is held
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic            wclk,
  input  logic            wrst,
  input  logic [3:0]      req_valid,
  input  logic [4*DW-1:0] req_data,
  input  logic [3:0]      req_last,
  output logic [3:0]      req_ready,
  input  logic            wfull,
  output logic            winc,
  output logic [DW-1:0]   wdata,
  output logic [1:0]      grant_id,
  output logic            busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic [7:0] beat_cnt;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       last_beat;

  // Round-robin search: scan last_grant+1, +2, +3, +4 (mod 4) and keep the first hit.
  always_comb begin
    winner = last_grant + 2'd1;
    found  = 1'b0;
    cand   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Write path is combinational so a source can stream one word per cycle.
  always_comb begin
    winc      = (state == XFER) && req_valid[grant_id] && !wfull;
    req_ready = winc ? (4'b0001 << grant_id) : 4'b0000;
    wdata     = req_data[grant_id*DW +: DW];
    // This beat ends the grant if the source marks it last or the burst limit is hit.
    last_beat = req_last[grant_id] || (({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST));
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state      <= IDLE;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      beat_cnt   <= 8'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= XFER;
            busy     <= 1'b1;
            grant_id <= winner;
            beat_cnt <= 8'd0;
          end
        end
        XFER: begin
          if (winc) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              // Returning through IDLE guarantees a gap cycle between grants.
              state      <= IDLE;
              busy       <= 1'b0;
              last_grant <= grant_id;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, width of each requester's data word and of wdata.
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum beats per grant; legal range 1..255.
REQ-003 SHALL have port wclk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port wrst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 4, per-requester word-valid.
REQ-006 SHALL have port req_data, input, 4*DW, requester k's word in bits [k*DW +: DW].
REQ-007 SHALL have port req_last, input, 4, per-requester end-of-packet flag, qualified by req_valid.
REQ-008 SHALL have port req_ready, output, 4, per-requester word-accepted strobe.
REQ-009 SHALL have port wfull, input, 1, FIFO write-side full flag.
REQ-010 SHALL have port winc, output, 1, FIFO write-increment.
REQ-011 SHALL have port wdata, output, DW, FIFO write data.
REQ-012 SHALL have port grant_id, output, 2, index of the currently granted requester.
REQ-013 SHALL have port busy, output, 1, high while a grant is held (state XFER).

Function
REQ-014 SHALL implement a two-state FSM, IDLE and XFER.
REQ-015 In IDLE with any req_valid bit high, the FSM SHALL register the winner into grant_id and move to XFER on the next edge, regardless of wfull.
REQ-016 Arbitration SHALL be round-robin: search starts at last_grant+1 mod 4 and picks the first index with req_valid high.
REQ-017 In IDLE with req_valid==0, the FSM SHALL stay in IDLE and leave grant_id and last_grant unchanged.
REQ-018 In XFER, the block SHALL drive winc = req_valid[grant_id] & ~wfull, combinationally.
REQ-019 In XFER, req_ready[grant_id] SHALL equal winc, and all other req_ready bits SHALL be 0.
REQ-020 wdata SHALL equal req_data slice grant_id in XFER; its value in IDLE is don't-care.
REQ-021 In IDLE, winc and req_ready SHALL be 0.
REQ-022 A beat SHALL count only when winc=1; an 8-bit beat_cnt SHALL increment per beat and clear on entry to XFER.
REQ-023 XFER SHALL end after a beat with req_last[grant_id]=1, or after beat MAX_BURST, whichever comes first.
REQ-024 When XFER ends, the FSM SHALL return to IDLE and set last_grant to grant_id.
REQ-025 After every packet, at least one IDLE cycle SHALL occur before the next grant.
REQ-026 wfull high in XFER SHALL stall: winc=0, grant held, and beat_cnt held.
REQ-027 The granted requester dropping req_valid mid-packet SHALL hold the grant; there is no timeout.
REQ-028 A burst truncated at MAX_BURST SHALL leave the requester's remaining words for a later grant; the arbiter does not track packet boundaries across grants.
REQ-029 Requests from non-granted requesters during XFER SHALL be ignored until the next IDLE.

Reset
REQ-030 While wrst=1, the block SHALL force state=IDLE, grant_id=0, last_grant=3, beat_cnt=0, busy=0, winc=0, req_ready=0.
REQ-031 Reset asserted mid-XFER SHALL abort the packet immediately, without completing the in-flight beat.
REQ-032 After wrst falls, the first arbitration SHALL give requester 0 the highest priority.

Verification
REQ-033 Reset, then req_valid=4'b1111 with req_last held 1 -> grants in order 0,1,2,3,0, each one beat with one IDLE cycle between grants.
REQ-034 Requester 2 sends 5 words with last on word 5, wfull=0 -> busy high for 5 cycles, winc high for 5 consecutive cycles, wdata follows req_data[2].
REQ-035 Granted transfer with wfull raised for 3 cycles after beat 2 -> winc=0 and req_ready=0 for those 3 cycles, grant_id unchanged, all words delivered in order.
REQ-036 MAX_BURST=8, requester 1 streams 12 words with no last, requester 3 valid -> 8 beats to requester 1, then a grant to requester 3, then requester 1 resumes.
REQ-037 wrst pulsed during beat 3 of a packet from requester 2 -> winc=0 and busy=0 at once; after release, req_valid=4'b0110 grants requester 1 first.
REQ-038 Granted requester deasserts req_valid for 4 cycles mid-packet while requester 0 is valid -> grant held, no winc, requester 0 not served until the packet ends.
